multi_cycle_controller: RTL and testbench

- Moore-style main FSM of the multi-cycle processor: fetch, decode, execute, memory and writeback steps.
- Drives the 3-bit ALU ctrl, datapath mux selects and write strobes each cycle.
- Holds the architectural NZCV flag register and evaluates the 4-bit condition field.
- Sits between the instruction register fields and the shared datapath (ALU, register file, memory, PC).

---
 rtl/multi_cycle_controller_pkg.sv | 112 +++++++++++
 rtl/multi_cycle_controller_if.sv | 39 +++
 rtl/multi_cycle_controller_cond_check.sv | 34 +++
 rtl/multi_cycle_controller.sv | 103 ++++++++++
 tb/tb_multi_cycle_controller.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_controller_pkg.sv
// Shared types and encodings for the multi-cycle processor controller:
// FSM states, ALU/op/condition codes, mux selects and the per-state control word.
package multi_cycle_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXEC    = 4'd2,
    ALU_WB  = 4'd3,
    MEM_ADR = 4'd4,
    MEM_RD  = 4'd5,
    MEM_WB  = 4'd6,
    MEM_WR  = 4'd7,
    BRANCH  = 4'd8,
    TRAP    = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_RSB = 3'b010;
  localparam logic [2:0] ALU_BIC = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_ORR = 3'b101;
  localparam logic [2:0] ALU_EOR = 3'b110;
  localparam logic [2:0] ALU_CLR = 3'b111;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_GE = 4'b1000;
  localparam logic [3:0] COND_LT = 4'b1001;
  localparam logic [3:0] COND_GT = 4'b1010;
  localparam logic [3:0] COND_LE = 4'b1011;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] result_src;
  } ctrl_t;

  // Moore output table; cmd/imm only matter in EXEC, where they come from the IR
  function automatic ctrl_t state_ctrl(state_t s, logic [2:0] cmd, logic imm);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_ctrl   = ALU_ADD;
        c.result_src = RES_ALU;
        c.pc_write   = 1'b1;
      end
      DECODE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_ctrl  = ALU_ADD;
      end
      EXEC: begin
        c.alu_src_b = {1'b0, imm};
        c.alu_ctrl  = cmd;
      end
      ALU_WB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      MEM_ADR: c.alu_src_b = SRCB_IMM;
      MEM_RD:  c.adr_src = 1'b1;
      MEM_WB: begin
        c.result_src = RES_MEM;
        c.reg_write  = 1'b1;
      end
      MEM_WR: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      BRANCH: begin
        c.alu_src_b  = SRCB_IMM;
        c.result_src = RES_ALU;
        c.pc_write   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath bundle: IR fields and ALU flags in, control strobes/selects out.
interface multi_cycle_controller_if;
  logic [3:0] instr_cond;
  logic [1:0] instr_op;
  logic       instr_i;
  logic [2:0] instr_cmd;
  logic       instr_s;
  logic       instr_l;
  logic       alu_n;
  logic       alu_z;
  logic       alu_co;
  logic       alu_ovf;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [1:0] result_src;
  logic [3:0] flags_q;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  instr_cond, instr_op, instr_i, instr_cmd, instr_s, instr_l,
    input  alu_n, alu_z, alu_co, alu_ovf,
    output pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a,
    output alu_src_b, alu_ctrl, result_src, flags_q, illegal, state_o
  );

  modport slave (
    output instr_cond, instr_op, instr_i, instr_cmd, instr_s, instr_l,
    output alu_n, alu_z, alu_co, alu_ovf,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a,
    input  alu_src_b, alu_ctrl, result_src, flags_q, illegal, state_o
  );
endinterface

// File: rtl/multi_cycle_controller_cond_check.sv
// Combinational condition-field evaluator against {N,Z,C,V}; reused by pipeline work.
module cond_check
  import multi_cycle_pkg::*;
#(
  parameter int COND_W = 4
) (
  input  logic [COND_W-1:0] cond,
  input  logic [3:0]        flags,
  output logic              pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  // 1100, 1101 and 1111 fall through to the default and never execute
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/multi_cycle_controller.sv
// Main Moore FSM of the multi-cycle processor with registered control outputs and NZCV flags.
// Optional ILLEGAL_OP_TRAP_EN: op 11 with passing condition locks into TRAP and sets 'illegal'.
module multi_cycle_controller
  import multi_cycle_pkg::*;
#(
  parameter int COND_W  = 4,
  parameter int STATE_W = 4
) (
  input logic                      clk,
  input logic                      rst,
  multi_cycle_controller_if.master bus
);
  state_t     state;
  ctrl_t      ctrl_q;
  ctrl_t      ctrl_out;
  logic [3:0] flags_q;
  logic       cond_pass;

  cond_check #(.COND_W(COND_W)) u_cond (
    .cond  (bus.instr_cond),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  function automatic state_t next_state(state_t s, logic pass, logic [1:0] op, logic ld);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:   n = DECODE;
      DECODE: begin
        if (!pass)              n = FETCH;
        else if (op == OP_DP)   n = EXEC;
        else if (op == OP_MEM)  n = MEM_ADR;
        else if (op == OP_BR)   n = BRANCH;
        else
`ifdef ILLEGAL_OP_TRAP_EN
                                n = TRAP;
`else
                                n = FETCH;
`endif
      end
      EXEC:    n = ALU_WB;
      MEM_ADR: n = ld ? MEM_RD : MEM_WR;
      MEM_RD:  n = MEM_WB;
`ifdef ILLEGAL_OP_TRAP_EN
      TRAP:    n = TRAP;
`endif
      default: n = FETCH;
    endcase
    return n;
  endfunction

  // Output register is loaded with the next state's control word so it lines up with state
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      ctrl_q  <= state_ctrl(FETCH, ALU_ADD, 1'b0);
      flags_q <= 4'b0000;
    end else begin
      state  <= next_state(state, cond_pass, bus.instr_op, bus.instr_l);
      ctrl_q <= state_ctrl(next_state(state, cond_pass, bus.instr_op, bus.instr_l),
                           bus.instr_cmd, bus.instr_i);
      if (state == ALU_WB && bus.instr_s) begin
        flags_q[3] <= bus.alu_n;
        flags_q[2] <= bus.alu_z;
        if (bus.instr_cmd == ALU_ADD || bus.instr_cmd == ALU_SUB || bus.instr_cmd == ALU_RSB) begin
          flags_q[1] <= bus.alu_co;
          flags_q[0] <= bus.alu_ovf;
        end
      end
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (rst)
      illegal_q <= 1'b0;
    else if (state == DECODE && cond_pass && bus.instr_op == OP_ILL)
      illegal_q <= 1'b1;
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  // Reset must silence strobes and selects immediately, not one edge later
  assign ctrl_out = rst ? '0 : ctrl_q;

  assign bus.pc_write   = ctrl_out.pc_write;
  assign bus.adr_src    = ctrl_out.adr_src;
  assign bus.mem_write  = ctrl_out.mem_write;
  assign bus.ir_write   = ctrl_out.ir_write;
  assign bus.reg_write  = ctrl_out.reg_write;
  assign bus.alu_src_a  = ctrl_out.alu_src_a;
  assign bus.alu_src_b  = ctrl_out.alu_src_b;
  assign bus.alu_ctrl   = ctrl_out.alu_ctrl;
  assign bus.result_src = ctrl_out.result_src;
  assign bus.flags_q    = flags_q;
  assign bus.state_o    = STATE_W'(state);
endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: walks every instruction class cycle by cycle.
module tb_multi_cycle_controller;
  import multi_cycle_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multi_cycle_controller_if bus ();

  multi_cycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a, alu_src_b, alu_ctrl, result_src}
  logic [12:0] ctrlNow;
  assign ctrlNow = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                    bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.result_src};

  localparam logic [12:0] C_ZERO   = 13'b0_0_0_0_0_0_00_000_00;
  localparam logic [12:0] C_FETCH  = 13'b1_0_0_1_0_1_10_000_10;
  localparam logic [12:0] C_DECODE = 13'b0_0_0_0_0_1_10_000_00;
  localparam logic [12:0] C_ALUWB  = 13'b0_0_0_0_1_0_00_000_00;
  localparam logic [12:0] C_MEMADR = 13'b0_0_0_0_0_0_01_000_00;
  localparam logic [12:0] C_MEMRD  = 13'b0_1_0_0_0_0_00_000_00;
  localparam logic [12:0] C_MEMWB  = 13'b0_0_0_0_1_0_00_000_01;
  localparam logic [12:0] C_MEMWR  = 13'b0_1_1_0_0_0_00_000_00;
  localparam logic [12:0] C_BRANCH = 13'b1_0_0_0_0_0_01_000_10;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] cond, input logic [1:0] op, input logic imm,
                               input logic [2:0] cmd, input logic s, input logic ld,
                               input logic [3:0] aluFlags);
    bus.instr_cond = cond;
    bus.instr_op   = op;
    bus.instr_i    = imm;
    bus.instr_cmd  = cmd;
    bus.instr_s    = s;
    bus.instr_l    = ld;
    {bus.alu_n, bus.alu_z, bus.alu_co, bus.alu_ovf} = aluFlags;
  endtask

  // Checks one cycle at its falling edge, then returns just after the closing rising edge
  task automatic expectCycle(input string tag, input state_t st, input logic [12:0] ctrl,
                             input logic [3:0] flags, input logic ill);
    @(negedge clk);
    checkOutput({tag, ".state"}, 32'(bus.state_o), 32'(st));
    checkOutput({tag, ".ctrl"}, 32'(ctrlNow), 32'(ctrl));
    checkOutput({tag, ".flags"}, 32'(bus.flags_q), 32'(flags));
    checkOutput({tag, ".illegal"}, 32'(bus.illegal), 32'(ill));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(COND_AL, OP_DP, 1'b0, ALU_ADD, 1'b0, 1'b0, 4'b0000);
    @(posedge clk);
    #1;
    repeat (3) expectCycle("reset", FETCH, C_ZERO, 4'b0000, 1'b0);
    rst = 1'b0;

    // SUB, S=1: ALU n0 z1 c1 v0 -> flags 0110 after write-back
    applyStimulus(COND_AL, OP_DP, 1'b0, ALU_SUB, 1'b1, 1'b0, 4'b0110);
    expectCycle("sub.fetch",  FETCH,  C_FETCH,  4'b0000, 1'b0);
    expectCycle("sub.decode", DECODE, C_DECODE, 4'b0000, 1'b0);
    expectCycle("sub.exec",   EXEC,   13'b0_0_0_0_0_0_00_001_00, 4'b0000, 1'b0);
    expectCycle("sub.wb",     ALU_WB, C_ALUWB,  4'b0000, 1'b0);

    // ADD, S=1: n0 z0 c1 v1 -> 0011
    applyStimulus(COND_AL, OP_DP, 1'b0, ALU_ADD, 1'b1, 1'b0, 4'b0011);
    expectCycle("add.fetch",  FETCH,  C_FETCH,  4'b0110, 1'b0);
    expectCycle("add.decode", DECODE, C_DECODE, 4'b0110, 1'b0);
    expectCycle("add.exec",   EXEC,   13'b0_0_0_0_0_0_00_000_00, 4'b0110, 1'b0);
    expectCycle("add.wb",     ALU_WB, C_ALUWB,  4'b0110, 1'b0);

    // ORR imm, S=1: n1 z0, C/V retained (1,1) -> 1011
    applyStimulus(COND_AL, OP_DP, 1'b1, ALU_ORR, 1'b1, 1'b0, 4'b1000);
    expectCycle("orr.fetch",  FETCH,  C_FETCH,  4'b0011, 1'b0);
    expectCycle("orr.decode", DECODE, C_DECODE, 4'b0011, 1'b0);
    expectCycle("orr.exec",   EXEC,   13'b0_0_0_0_0_0_01_101_00, 4'b0011, 1'b0);
    expectCycle("orr.wb",     ALU_WB, C_ALUWB,  4'b0011, 1'b0);

    // CLR, S=1 -> {0,1,C_old,V_old} = 0111
    applyStimulus(COND_AL, OP_DP, 1'b0, ALU_CLR, 1'b1, 1'b0, 4'b0100);
    expectCycle("clr.fetch",  FETCH,  C_FETCH,  4'b1011, 1'b0);
    expectCycle("clr.decode", DECODE, C_DECODE, 4'b1011, 1'b0);
    expectCycle("clr.exec",   EXEC,   13'b0_0_0_0_0_0_00_111_00, 4'b1011, 1'b0);
    expectCycle("clr.wb",     ALU_WB, C_ALUWB,  4'b1011, 1'b0);

    // ADD with S=0 leaves flags alone
    applyStimulus(COND_AL, OP_DP, 1'b0, ALU_ADD, 1'b0, 1'b0, 4'b1100);
    expectCycle("nos.fetch",  FETCH,  C_FETCH,  4'b0111, 1'b0);
    expectCycle("nos.decode", DECODE, C_DECODE, 4'b0111, 1'b0);
    expectCycle("nos.exec",   EXEC,   13'b0_0_0_0_0_0_00_000_00, 4'b0111, 1'b0);
    expectCycle("nos.wb",     ALU_WB, C_ALUWB,  4'b0111, 1'b0);

    applyStimulus(COND_AL, OP_MEM, 1'b0, ALU_ADD, 1'b1, 1'b1, 4'b1000);
    expectCycle("ldr.fetch",  FETCH,   C_FETCH,  4'b0111, 1'b0);
    expectCycle("ldr.decode", DECODE,  C_DECODE, 4'b0111, 1'b0);
    expectCycle("ldr.adr",    MEM_ADR, C_MEMADR, 4'b0111, 1'b0);
    expectCycle("ldr.rd",     MEM_RD,  C_MEMRD,  4'b0111, 1'b0);
    expectCycle("ldr.wb",     MEM_WB,  C_MEMWB,  4'b0111, 1'b0);

    applyStimulus(COND_AL, OP_MEM, 1'b0, ALU_ADD, 1'b1, 1'b0, 4'b1000);
    expectCycle("str.fetch",  FETCH,   C_FETCH,  4'b0111, 1'b0);
    expectCycle("str.decode", DECODE,  C_DECODE, 4'b0111, 1'b0);
    expectCycle("str.adr",    MEM_ADR, C_MEMADR, 4'b0111, 1'b0);
    expectCycle("str.wr",     MEM_WR,  C_MEMWR,  4'b0111, 1'b0);

    // GT fails with Z=1
    applyStimulus(COND_GT, OP_DP, 1'b0, ALU_ADD, 1'b1, 1'b0, 4'b1111);
    expectCycle("gt.fetch",  FETCH,  C_FETCH,  4'b0111, 1'b0);
    expectCycle("gt.decode", DECODE, C_DECODE, 4'b0111, 1'b0);

    // LT passes with N=0,V=1; AND S=1 n0 z0 -> 0011
    applyStimulus(COND_LT, OP_DP, 1'b0, ALU_AND, 1'b1, 1'b0, 4'b0000);
    expectCycle("lt.fetch",  FETCH,  C_FETCH,  4'b0111, 1'b0);
    expectCycle("lt.decode", DECODE, C_DECODE, 4'b0111, 1'b0);
    expectCycle("lt.exec",   EXEC,   13'b0_0_0_0_0_0_00_100_00, 4'b0111, 1'b0);
    expectCycle("lt.wb",     ALU_WB, C_ALUWB,  4'b0111, 1'b0);

    // BEQ with Z=0 is skipped in 2 cycles
    applyStimulus(COND_EQ, OP_BR, 1'b0, ALU_ADD, 1'b0, 1'b0, 4'b0000);
    expectCycle("beq0.fetch",  FETCH,  C_FETCH,  4'b0011, 1'b0);
    expectCycle("beq0.decode", DECODE, C_DECODE, 4'b0011, 1'b0);

    // Never-execute condition must not touch flags
    applyStimulus(4'b1111, OP_DP, 1'b0, ALU_CLR, 1'b1, 1'b0, 4'b0100);
    expectCycle("nv.fetch",  FETCH,  C_FETCH,  4'b0011, 1'b0);
    expectCycle("nv.decode", DECODE, C_DECODE, 4'b0011, 1'b0);

    applyStimulus(COND_AL, OP_DP, 1'b0, ALU_CLR, 1'b1, 1'b0, 4'b0100);
    expectCycle("clr2.fetch",  FETCH,  C_FETCH,  4'b0011, 1'b0);
    expectCycle("clr2.decode", DECODE, C_DECODE, 4'b0011, 1'b0);
    expectCycle("clr2.exec",   EXEC,   13'b0_0_0_0_0_0_00_111_00, 4'b0011, 1'b0);
    expectCycle("clr2.wb",     ALU_WB, C_ALUWB,  4'b0011, 1'b0);

    // BEQ with Z=1 is taken in 3 cycles
    applyStimulus(COND_EQ, OP_BR, 1'b0, ALU_ADD, 1'b0, 1'b0, 4'b0000);
    expectCycle("beq1.fetch",  FETCH,  C_FETCH,  4'b0111, 1'b0);
    expectCycle("beq1.decode", DECODE, C_DECODE, 4'b0111, 1'b0);
    expectCycle("beq1.branch", BRANCH, C_BRANCH, 4'b0111, 1'b0);

    // Store aborted by reset during MEM_ADR: no mem_write ever appears
    applyStimulus(COND_AL, OP_MEM, 1'b0, ALU_ADD, 1'b0, 1'b0, 4'b0000);
    expectCycle("abort.fetch",  FETCH,  C_FETCH,  4'b0111, 1'b0);
    expectCycle("abort.decode", DECODE, C_DECODE, 4'b0111, 1'b0);
    rst = 1'b1;
    expectCycle("abort.adr",    MEM_ADR, C_ZERO,  4'b0111, 1'b0);
    expectCycle("abort.rst",    FETCH,   C_ZERO,  4'b0000, 1'b0);
    rst = 1'b0;

    applyStimulus(COND_AL, OP_ILL, 1'b0, ALU_ADD, 1'b0, 1'b0, 4'b0000);
    expectCycle("ill.fetch",  FETCH,  C_FETCH,  4'b0000, 1'b0);
    expectCycle("ill.decode", DECODE, C_DECODE, 4'b0000, 1'b0);
`ifdef ILLEGAL_OP_TRAP_EN
    applyStimulus(COND_AL, OP_DP, 1'b0, ALU_ADD, 1'b1, 1'b0, 4'b1111);
    repeat (3) expectCycle("ill.trap", TRAP, C_ZERO, 4'b0000, 1'b1);
    rst = 1'b1;
    expectCycle("ill.rstcyc", TRAP,  C_ZERO, 4'b0000, 1'b1);
    expectCycle("ill.rsted",  FETCH, C_ZERO, 4'b0000, 1'b0);
    rst = 1'b0;
`endif
    expectCycle("end.fetch", FETCH, C_FETCH, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
